// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Picks the program counter's next address each cycle: increment,
//            jump, branch, call/return via a return stack, stall or halt hold.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int STACK_DEPTH           = 4,
    parameter int DEPTH_BITS            = $clog2(STACK_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instr_valid,
    input  logic [2:0]                       op,
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] target,
    input  logic                             flag_zero,
    input  logic                             flag_carry,
    input  logic                             stall_req,
    input  logic                             resume,
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] current_addr,
    output logic                             jump_enable,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value,
    output logic                             flush,
    output logic                             halted,
    output logic                             stack_err,
    output logic [DEPTH_BITS-1:0]            stack_depth
);

    localparam logic [2:0] C_OP_JMP  = 3'b001;
    localparam logic [2:0] C_OP_JZ   = 3'b010;
    localparam logic [2:0] C_OP_JC   = 3'b011;
    localparam logic [2:0] C_OP_CALL = 3'b100;
    localparam logic [2:0] C_OP_RET  = 3'b101;
    localparam logic [2:0] C_OP_HALT = 3'b110;

    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] C_ADDR_ONE  = 1;
    localparam logic [DEPTH_BITS-1:0]            C_DEPTH_ONE = 1;
    localparam logic [DEPTH_BITS-1:0]            C_DEPTH_MAX = DEPTH_BITS'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [DEPTH_BITS-1:0]            sp_q, sp_d;
    logic                             err_q, err_d;
    logic [BITS_FOR_INSTRUCTIONS-1:0] stack_q [STACK_DEPTH];
    logic [BITS_FOR_INSTRUCTIONS-1:0] stack_d [STACK_DEPTH];
    logic [BITS_FOR_INSTRUCTIONS-1:0] w_top;
    logic [BITS_FOR_INSTRUCTIONS-1:0] w_next_addr;

    assign w_next_addr = current_addr + C_ADDR_ONE;

    // Entry just below the stack pointer; only meaningful when depth > 0.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DEPTH_BITS'(i) == sp_q - C_DEPTH_ONE) begin
                w_top = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        err_d       = err_q;
        stack_d     = stack_q;
        jump_enable = 1'b0;
        jump_value  = current_addr;
        flush       = 1'b0;

        if (rst) begin
            jump_enable = 1'b1;
            jump_value  = '0;
            state_d     = S_RUN;
            sp_d        = '0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stall_req) begin
                        jump_enable = 1'b1;
                    end else if (instr_valid) begin
                        case (op)
                            C_OP_JMP: begin
                                jump_enable = 1'b1;
                                jump_value  = target;
                                flush       = 1'b1;
                            end
                            C_OP_JZ, C_OP_JC: begin
                                if ((op == C_OP_JZ) ? flag_zero : flag_carry) begin
                                    jump_enable = 1'b1;
                                    jump_value  = target;
                                    flush       = 1'b1;
                                end
                            end
                            C_OP_CALL: begin
                                jump_enable = 1'b1;
                                if (sp_q == C_DEPTH_MAX) begin
                                    state_d = S_ERROR;
                                    err_d   = 1'b1;
                                end else begin
                                    for (int i = 0; i < STACK_DEPTH; i++) begin
                                        if (DEPTH_BITS'(i) == sp_q) begin
                                            stack_d[i] = w_next_addr;
                                        end
                                    end
                                    sp_d       = sp_q + C_DEPTH_ONE;
                                    jump_value = target;
                                    flush      = 1'b1;
                                end
                            end
                            C_OP_RET: begin
                                jump_enable = 1'b1;
                                if (sp_q == '0) begin
                                    state_d = S_ERROR;
                                    err_d   = 1'b1;
                                end else begin
                                    sp_d       = sp_q - C_DEPTH_ONE;
                                    jump_value = w_top;
                                    flush      = 1'b1;
                                end
                            end
                            C_OP_HALT: begin
                                jump_enable = 1'b1;
                                state_d     = S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_HALT: begin
                    jump_enable = 1'b1;
                    if (resume) begin
                        jump_value = w_next_addr;
                        state_d    = S_RUN;
                    end
                end
                S_ERROR: begin
                    jump_enable = 1'b1;
                end
                default: begin
                    jump_enable = 1'b1;
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign halted      = (state_q == S_HALT);
    assign stack_err   = err_q;
    assign stack_depth = sp_q;

endmodule
`default_nettype wire
